ising_sweep_core: RTL

//  Clocked, parametrised successor to the free-running coupled-oscillator array.

---
 rtl/ising_sweep_core.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ising_sweep_core.sv
// Sequential-sweep Ising solver: N spins, upper-triangular coupling store, one spin
// updated per clock until a flip-free sweep or the sweep cap. Optional ISING_ENERGY_EN.
module ising_sweep_core #(
  parameter int N           = 4,
  parameter int NUM_WEIGHTS = 5,
  parameter int SWEEP_BITS  = 8,
  localparam int WB   = $clog2(NUM_WEIGHTS),
  localparam int NP   = N * (N - 1) / 2,
  localparam int AW   = (NP > 1) ? $clog2(NP) : 1,
  localparam int WMAX = (NUM_WEIGHTS - 1) / 2,
  localparam int HB   = $clog2(WMAX * (N - 1) + 1) + 1,
  localparam int KB   = $clog2(N),
  localparam int EW   = HB + $clog2(N) + 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WB-1:0]         wr_data,
  input  logic                  start,
  input  logic [N-1:0]          spin_init,
  input  logic [SWEEP_BITS-1:0] max_sweeps,
  output logic                  busy,
  output logic                  done,
  output logic                  converged,
  output logic [SWEEP_BITS-1:0] sweeps_used,
  output logic                  state_dbg,
  output logic [N-1:0]          spins
`ifdef ISING_ENERGY_EN
  ,
  output logic signed [EW-1:0]  energy_delta
`endif
);

  // Handshake: a weight write transfers on any rising edge where wr_valid && wr_ready;
  // wr_valid may be held or dropped freely, wr_ready depends only on the FSM state.

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [WB-1:0]           w_q [NP];
  logic [N-1:0]            spins_q;
  logic [KB-1:0]           k_q;
  logic [SWEEP_BITS-1:0]   sweeps_q;
  logic [SWEEP_BITS-1:0]   max_q;
  logic                    sweep_flip_q;
  logic                    done_q;
  logic                    conv_q;

  logic signed [HB-1:0]    h;
  logic                    new_s;
  logic                    flip;
  logic                    last_k;
  logic                    any_flip;
  logic                    cap_hit;
  logic                    finish;
  int                      acc;
  int                      kk;
  int                      p;

  function automatic int pair_idx(input int i, input int j);
    return N * i - i * (i + 1) / 2 + j - i - 1;
  endfunction

  // Local field of spin k over all other spins, signed +/-1 spin encoding.
  always_comb begin
    acc = 0;
    p   = 0;
    kk  = int'(k_q);
    for (int j = 0; j < N; j++) begin
      if (j != kk) begin
        p = (j < kk) ? pair_idx(j, kk) : pair_idx(kk, j);
        if (spins_q[j]) acc = acc + (int'(w_q[p]) - WMAX);
        else            acc = acc - (int'(w_q[p]) - WMAX);
      end
    end
    h = HB'(acc);
  end

  always_comb begin
    new_s = spins_q[k_q];
    if (h > 0)      new_s = 1'b1;
    else if (h < 0) new_s = 1'b0;
    flip     = (new_s != spins_q[k_q]);
    last_k   = (k_q == KB'(N - 1));
    any_flip = sweep_flip_q | flip;
    cap_hit  = ((sweeps_q + SWEEP_BITS'(1)) == max_q);
    finish   = last_k && (!any_flip || cap_hit);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (max_sweeps != '0)) state_d = RUN;
      RUN:     if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NP; i++) w_q[i] <= WB'(WMAX);
      spins_q      <= '0;
      k_q          <= '0;
      sweeps_q     <= '0;
      max_q        <= '0;
      sweep_flip_q <= 1'b0;
      done_q       <= 1'b0;
      conv_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Out-of-range addresses complete the handshake but are dropped.
      if (wr_valid && wr_ready && (int'(wr_addr) < NP)) w_q[wr_addr] <= wr_data;
      case (state_q)
        IDLE: begin
          if (start) begin
            spins_q      <= spin_init;
            k_q          <= '0;
            sweeps_q     <= '0;
            sweep_flip_q <= 1'b0;
            max_q        <= max_sweeps;
            if (max_sweeps == '0) done_q <= 1'b1;
          end
        end
        RUN: begin
          spins_q[k_q] <= new_s;
          if (flip) sweep_flip_q <= 1'b1;
          if (last_k) begin
            sweeps_q <= sweeps_q + SWEEP_BITS'(1);
            if (finish) begin
              done_q <= 1'b1;
              conv_q <= !any_flip;
            end else begin
              k_q          <= '0;
              sweep_flip_q <= 1'b0;
            end
          end else begin
            k_q <= k_q + KB'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ISING_ENERGY_EN
  logic signed [EW-1:0] energy_q;
  logic signed [EW-1:0] h_ext;
  logic signed [EW-1:0] e_step;

  // Flipping s_k changes E by 2*s_k_old*h_k.
  always_comb begin
    h_ext  = EW'(h);
    e_step = spins_q[k_q] ? (h_ext <<< 1) : -(h_ext <<< 1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) energy_q <= '0;
    else if (state_q == IDLE && start) energy_q <= '0;
    else if (state_q == RUN && flip) energy_q <= energy_q + e_step;
  end

  assign energy_delta = energy_q;
`endif

  assign wr_ready    = (state_q == IDLE);
  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign converged   = conv_q;
  assign sweeps_used = sweeps_q;
  assign spins       = spins_q;
  assign state_dbg   = state_q;

endmodule
